enc8b10b_rd_ctrl: RTL and testbench
===================================

Name: enc8b10b_rd_ctrl

Overview:
Sequencer for the 8b/10b lookup datapath in the JESD204B transmit lane. Accepts bytes from the link layer with a valid/ready handshake and issues reads to the RD- and RD+ symbol ROMs in parallel. Selects each 10-bit symbol by the current running disparity (RD), updates RD from the selected symbol's ones count, and presents symbols to the serializer with valid/ready. Flags unknown control characters and disparity inconsistencies.

Parameters:
RD_INIT, 0, running disparity after reset (0 = RD-, 1 = RD+)
ERR_STICKY, 0, 1 = o_k_error/o_disp_error hold once set until reset; 0 = per-symbol flags

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
i_data  in  8  byte HGFEDCBA
i_k  in  1  1 = control character
i_valid  in  1  upstream byte valid
o_ready  out  1  upstream ready; transfer when i_valid & o_ready
rom_addr  out  8  address to both ROMs (combinational mux)
rom_rd_en  out  1  ROM read strobe
rom_k  out  1  K select to both ROMs (k of entry at ROM outputs)
rdm_out  in  10  RD- ROM symbol abcdeifghj
rdm_k_error  in  1  RD- ROM unknown-K flag
rdp_out  in  10  RD+ ROM symbol
rdp_k_error  in  1  RD+ ROM unknown-K flag
o_symbol  out  10  encoded symbol abcdeifghj
o_valid  out  1  symbol valid
i_ready  in  1  downstream ready
o_rd  out  1  current running disparity
o_k_error  out  1  unknown control character on the presented symbol
o_disp_error  out  1  disparity inconsistency on the presented symbol

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Three stages:
  - A: address register; holds byte, k, a_v.
  - L: lookup result at the ROM outputs; holds byte, k, l_v.
  - O: output register; holds o_symbol, o_valid and the flags.
- Control equations:
  - capture = l_v & (!o_valid | i_ready)
  - rom_rd_en = a_v & (!l_v | capture); A moves to L on this edge.
  - o_ready = !rst & (!a_v | rom_rd_en).
  - rom_addr = (l_v & !capture) ? L.byte : A.byte. The ROM K path resamples its address every cycle, so it must see L's byte during a stall.
  - rom_k = L.k.
- Latency: byte accepted at edge N, symbol valid after edge N+2. Throughput is 1 symbol/clk while i_ready = 1.
- Stall: O holds o_symbol and flags stable while o_valid & !i_ready. Data is never dropped or duplicated.
- Symbol selection at capture:
  - sel = o_rd ? rdp_out : rdm_out; kerr = L.k & (o_rd ? rdp_k_error : rdm_k_error).
  - p = ones count of sel (0..10).
  - kerr = 1: o_symbol = sel; o_k_error = 1; RD unchanged.
  - p = 5: RD unchanged.
  - p = 6 and RD- before: RD becomes +.
  - p = 4 and RD+ before: RD becomes -.
  - Any other p (6 at RD+, 4 at RD-, p < 4, p > 6): o_disp_error = 1, RD unchanged.
  - RD (o_rd) updates on the capture edge, so back-to-back captures use the updated RD.
- Flags: with ERR_STICKY = 0, flags are valid with o_valid and replaced on each capture; otherwise they are OR-accumulated.
- Reset (rst = 1 at any edge, including mid-stream):
  - a_v, l_v, o_valid cleared; o_symbol 0; o_k_error 0; o_disp_error 0; o_rd = RD_INIT.
  - rom_rd_en 0; o_ready 0 during reset, 1 in the first cycle after.
  - In-flight bytes are discarded.
- Simultaneous accept + rom_rd_en + capture at the same edge is legal; all three stages advance.

Optional Feature:
ENC_DISP_CHECK_EN
- Defined: the disparity consistency check above drives o_disp_error.
- Undefined: o_disp_error tied 0. RD update reduces to: p > 5 → RD+, p < 5 → RD-, p = 5 unchanged. Popcount logic beyond that comparison is removed.

Test Plan:
- Reset with RD_INIT=0; send K28.5, K28.5 (i_k=1, 0xBC) with i_ready=1 → symbols 0011111010 then 1100000101; o_rd goes 1 then 0; first o_valid 2 cycles after the first accept; no flags.
- D21.5 (0xB5) x4 from RD- → 1010101010 each; o_rd stays 0; 1 symbol/clk.
- D0.0 (0x00, k=0) at RD- → 1001110100; o_rd stays 0. Then K28.5 → 0011111010; o_rd=1.
- Stream 0xB5, 0xBC(K), 0x00 with i_ready low 3 cycles after the first o_valid → o_symbol stable throughout the stall; o_ready drops once A and L are full; all 3 symbols delivered in order with correct RD.
- i_k=1, i_data=0x00 → o_k_error=1 on that symbol; o_rd unchanged; following D21.5 has o_k_error=0 (ERR_STICKY=0) or 1 (ERR_STICKY=1).
- Assert rst for 1 cycle with 2 bytes in flight → o_valid=0 next cycle; o_rd=RD_INIT; no stale symbol emitted. A following K28.5 encodes as the RD_INIT variant.

Source files
------------

// File: rtl/enc8b10b_rd_ctrl.sv
// enc8b10b_rd_ctrl: 8b/10b lookup sequencer for a JESD204B transmit lane.
// Bytes enter through a valid/ready port, pass through an address stage (A)
// and a lookup stage (L) that waits on the RD-/RD+ symbol ROMs, and land in
// an output register (O). O picks the symbol for the current running
// disparity and updates RD from the ones count of the chosen symbol.
//
// Optional feature macro: ENC_DISP_CHECK_EN
//   defined   - a symbol whose ones count does not fit the current RD raises
//               o_disp_error and leaves RD unchanged.
//   undefined - o_disp_error stays 0; RD follows the sign of (ones - 5).
module enc8b10b_rd_ctrl #(
    parameter bit RD_INIT    = 1'b0,  // RD after reset (0 = RD-, 1 = RD+)
    parameter bit ERR_STICKY = 1'b0   // 1 = error flags accumulate until reset
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_data,
    input  logic       i_k,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [7:0] rom_addr,
    output logic       rom_rd_en,
    output logic       rom_k,
    input  logic [9:0] rdm_out,
    input  logic       rdm_k_error,
    input  logic [9:0] rdp_out,
    input  logic       rdp_k_error,
    output logic [9:0] o_symbol,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_rd,
    output logic       o_k_error,
    output logic       o_disp_error
);

    // A stage: byte waiting to be addressed into the ROMs
    logic       a_v_q, a_v_d;
    logic [7:0] a_byte_q, a_byte_d;
    logic       a_k_q, a_k_d;
    // L stage: byte whose lookup result sits on the ROM outputs
    logic       l_v_q, l_v_d;
    logic [7:0] l_byte_q, l_byte_d;
    logic       l_k_q, l_k_d;
    // O stage: presented symbol, flags and running disparity
    logic       o_valid_q, o_valid_d;
    logic [9:0] o_symbol_q, o_symbol_d;
    logic       o_k_err_q, o_k_err_d;
    logic       o_disp_err_q, o_disp_err_d;
    logic       o_rd_q, o_rd_d;

    logic       capture;
    logic       rd_en;
    logic       ready;
    logic       accept;
    logic [9:0] sel;
    logic       kerr;
    logic       derr;
    logic       rd_nxt;
    logic [3:0] pop;

    function automatic logic [3:0] ones10(input logic [9:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 10; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    // Pipeline handshake: O frees, then L drains into O, then A into L.
    // The ROM address follows L while L is stuck so the K-error path,
    // which resamples every cycle, keeps describing the byte in L.
    always_comb begin
        capture = l_v_q & (~o_valid_q | i_ready);
        rd_en   = ~rst & a_v_q & (~l_v_q | capture);
        ready   = ~rst & (~a_v_q | rd_en);
        accept  = i_valid & ready;
        rom_addr = (l_v_q & ~capture) ? l_byte_q : a_byte_q;
    end

    assign o_ready      = ready;
    assign rom_rd_en    = rd_en;
    assign rom_k        = l_k_q;
    assign o_symbol     = o_symbol_q;
    assign o_valid      = o_valid_q;
    assign o_rd         = o_rd_q;
    assign o_k_error    = o_k_err_q;
    assign o_disp_error = o_disp_err_q;

    // Symbol selection by current RD and the RD / error decision for it
    always_comb begin
        sel    = o_rd_q ? rdp_out : rdm_out;
        kerr   = l_k_q & (o_rd_q ? rdp_k_error : rdm_k_error);
        pop    = ones10(sel);
        rd_nxt = o_rd_q;
        derr   = 1'b0;
        if (!kerr) begin
`ifdef ENC_DISP_CHECK_EN
            // Only a balanced symbol or a +/-1 swing against the current RD
            // is legal; anything else is reported and RD is left alone.
            case (pop)
                4'd5: rd_nxt = o_rd_q;
                4'd6: begin
                    if (!o_rd_q) rd_nxt = 1'b1;
                    else         derr   = 1'b1;
                end
                4'd4: begin
                    if (o_rd_q) rd_nxt = 1'b0;
                    else        derr   = 1'b1;
                end
                default: derr = 1'b1;
            endcase
`else
            if (pop > 4'd5)      rd_nxt = 1'b1;
            else if (pop < 4'd5) rd_nxt = 1'b0;
`endif
        end
    end

    // Next state for the three stages
    always_comb begin
        a_v_d        = a_v_q;
        a_byte_d     = a_byte_q;
        a_k_d        = a_k_q;
        l_v_d        = l_v_q;
        l_byte_d     = l_byte_q;
        l_k_d        = l_k_q;
        o_valid_d    = o_valid_q;
        o_symbol_d   = o_symbol_q;
        o_k_err_d    = o_k_err_q;
        o_disp_err_d = o_disp_err_q;
        o_rd_d       = o_rd_q;

        if (accept) begin
            a_v_d    = 1'b1;
            a_byte_d = i_data;
            a_k_d    = i_k;
        end else if (rd_en) begin
            a_v_d = 1'b0;
        end

        if (rd_en) begin
            l_v_d    = 1'b1;
            l_byte_d = a_byte_q;
            l_k_d    = a_k_q;
        end else if (capture) begin
            l_v_d = 1'b0;
        end

        if (capture) begin
            o_valid_d  = 1'b1;
            o_symbol_d = sel;
            o_rd_d     = rd_nxt;
            if (ERR_STICKY) begin
                o_k_err_d    = o_k_err_q | kerr;
                o_disp_err_d = o_disp_err_q | derr;
            end else begin
                o_k_err_d    = kerr;
                o_disp_err_d = derr;
            end
        end else if (i_ready) begin
            o_valid_d = 1'b0;
        end
    end

    // State registers; reset discards everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            a_v_q        <= 1'b0;
            a_byte_q     <= '0;
            a_k_q        <= 1'b0;
            l_v_q        <= 1'b0;
            l_byte_q     <= '0;
            l_k_q        <= 1'b0;
            o_valid_q    <= 1'b0;
            o_symbol_q   <= '0;
            o_k_err_q    <= 1'b0;
            o_disp_err_q <= 1'b0;
            o_rd_q       <= RD_INIT;
        end else begin
            a_v_q        <= a_v_d;
            a_byte_q     <= a_byte_d;
            a_k_q        <= a_k_d;
            l_v_q        <= l_v_d;
            l_byte_q     <= l_byte_d;
            l_k_q        <= l_k_d;
            o_valid_q    <= o_valid_d;
            o_symbol_q   <= o_symbol_d;
            o_k_err_q    <= o_k_err_d;
            o_disp_err_q <= o_disp_err_d;
            o_rd_q       <= o_rd_d;
        end
    end

endmodule

// File: tb/tb_enc8b10b_rd_ctrl.sv
// Bench for enc8b10b_rd_ctrl: RD-/RD+ ROMs are modelled from the 8b/10b
// code tables; a scoreboard re-encodes each accepted byte and applies the
// running-disparity rules to predict symbol, flags and RD.
module tb_enc8b10b_rd_ctrl;
    localparam bit P_RD_INIT = 1'b0;
    localparam bit P_STICKY  = 1'b0;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_data;
    logic       i_k;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] rom_addr;
    logic       rom_rd_en;
    logic       rom_k;
    logic [9:0] rdm_out;
    logic       rdm_k_error;
    logic [9:0] rdp_out;
    logic       rdp_k_error;
    logic [9:0] o_symbol;
    logic       o_valid;
    logic       i_ready;
    logic       o_rd;
    logic       o_k_error;
    logic       o_disp_error;

    enc8b10b_rd_ctrl #(.RD_INIT(P_RD_INIT), .ERR_STICKY(P_STICKY)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_k(i_k), .i_valid(i_valid),
        .o_ready(o_ready), .rom_addr(rom_addr), .rom_rd_en(rom_rd_en),
        .rom_k(rom_k), .rdm_out(rdm_out), .rdm_k_error(rdm_k_error),
        .rdp_out(rdp_out), .rdp_k_error(rdp_k_error), .o_symbol(o_symbol),
        .o_valid(o_valid), .i_ready(i_ready), .o_rd(o_rd),
        .o_k_error(o_k_error), .o_disp_error(o_disp_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit corrupt = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- 8b/10b code tables ----------------
    function automatic logic [5:0] t6(input logic [4:0] x);
        case (x)
            5'd0: return 6'b100111;  5'd1: return 6'b011101;
            5'd2: return 6'b101101;  5'd3: return 6'b110001;
            5'd4: return 6'b110101;  5'd5: return 6'b101001;
            5'd6: return 6'b011001;  5'd7: return 6'b111000;
            5'd8: return 6'b111001;  5'd9: return 6'b100101;
            5'd10: return 6'b010101; 5'd11: return 6'b110100;
            5'd12: return 6'b001101; 5'd13: return 6'b101100;
            5'd14: return 6'b011100; 5'd15: return 6'b010111;
            5'd16: return 6'b011011; 5'd17: return 6'b100011;
            5'd18: return 6'b010011; 5'd19: return 6'b110010;
            5'd20: return 6'b001011; 5'd21: return 6'b101010;
            5'd22: return 6'b011010; 5'd23: return 6'b111010;
            5'd24: return 6'b110011; 5'd25: return 6'b100110;
            5'd26: return 6'b010110; 5'd27: return 6'b110110;
            5'd28: return 6'b001110; 5'd29: return 6'b101110;
            5'd30: return 6'b011110; default: return 6'b101011;
        endcase
    endfunction

    function automatic logic [3:0] t4d(input logic [2:0] y);
        case (y)
            3'd0: return 4'b1011; 3'd1: return 4'b1001;
            3'd2: return 4'b0101; 3'd3: return 4'b1100;
            3'd4: return 4'b1101; 3'd5: return 4'b1010;
            3'd6: return 4'b0110; default: return 4'b1110;
        endcase
    endfunction

    function automatic logic [3:0] t4k(input logic [2:0] y);
        case (y)
            3'd0: return 4'b1011; 3'd1: return 4'b0110;
            3'd2: return 4'b1010; 3'd3: return 4'b1100;
            3'd4: return 4'b1101; 3'd5: return 4'b0101;
            3'd6: return 4'b1001; default: return 4'b0111;
        endcase
    endfunction

    function automatic bit kvalid(input logic [7:0] b);
        return (b[4:0] == 5'd28) ||
               (b[7:5] == 3'd7 && (b[4:0] == 5'd23 || b[4:0] == 5'd27 ||
                                   b[4:0] == 5'd29 || b[4:0] == 5'd30));
    endfunction

    // Full encoding of one byte starting from running disparity rd
    function automatic logic [9:0] enc(input logic [7:0] b, input logic k, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] s6;
        logic [3:0] s4;
        logic rd1, kk, a7;
        x  = b[4:0];
        y  = b[7:5];
        kk = k && kvalid(b);
        s6 = (kk && x == 5'd28) ? 6'b001111 : t6(x);
        if (rd && ($countones(s6) != 3 || x == 5'd7)) s6 = ~s6;
        rd1 = ($countones(s6) != 3) ? !rd : rd;
        if (kk) begin
            s4 = rd1 ? ~t4k(y) : t4k(y);
        end else begin
            a7 = (y == 3'd7) &&
                 ((!rd1 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                  ( rd1 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
            s4 = a7 ? 4'b0111 : t4d(y);
            if (rd1 && ($countones(s4) != 2 || y == 3'd3)) s4 = ~s4;
        end
        return {s6, s4};
    endfunction

    // ---------------- ROM model ----------------
    // Data outputs are registered on rom_rd_en; the K-error path resamples
    // its address on every edge.
    logic [7:0] rom_daddr = 8'h00;
    logic [7:0] rom_kaddr = 8'h00;
    always @(posedge clk) begin
        if (rom_rd_en) rom_daddr <= rom_addr;
        rom_kaddr <= rom_addr;
    end
    always_comb begin
        rdm_out = enc(rom_daddr, rom_k, 1'b0);
        rdp_out = enc(rom_daddr, rom_k, 1'b1);
        if (corrupt && !rom_k && rom_daddr == 8'hFF) begin
            rdm_out = 10'h3FF;
            rdp_out = 10'h3FF;
        end
        rdm_k_error = rom_k && !kvalid(rom_kaddr);
        rdp_k_error = rom_k && !kvalid(rom_kaddr);
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [9:0] sym;
        logic       rd;
        logic       kerr;
        logic       derr;
        int         cyc;
    } obs_t;

    logic [8:0] exp_q[$];
    obs_t       obs_q[$];
    logic       m_rd = P_RD_INIT;
    logic       m_kacc = 1'b0;
    logic       m_dacc = 1'b0;
    logic       hold_v = 1'b0;
    logic [11:0] hold_val = '0;

    always @(negedge clk) begin
        logic [8:0] e;
        logic [9:0] s;
        logic ke, de, nrd;
        int p;
        obs_t o;
        if (rst) begin
            exp_q.delete();
            m_rd   = P_RD_INIT;
            m_kacc = 1'b0;
            m_dacc = 1'b0;
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("stall_hold", {o_symbol, o_k_error, o_disp_error}, hold_val);
                chk("stall_vld", o_valid, 1'b1);
            end
            hold_v   = o_valid && !i_ready;
            hold_val = {o_symbol, o_k_error, o_disp_error};
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e  = exp_q.pop_front();
                    s  = (corrupt && !e[8] && e[7:0] == 8'hFF) ? 10'h3FF : enc(e[7:0], e[8], m_rd);
                    ke = e[8] && !kvalid(e[7:0]);
                    de = 1'b0;
                    nrd = m_rd;
                    p  = $countones(s);
                    if (!ke) begin
`ifdef ENC_DISP_CHECK_EN
                        if (p == 5) nrd = m_rd;
                        else if (p == 6 && !m_rd) nrd = 1'b1;
                        else if (p == 4 && m_rd) nrd = 1'b0;
                        else de = 1'b1;
`else
                        if (p > 5) nrd = 1'b1;
                        else if (p < 5) nrd = 1'b0;
`endif
                    end
                    m_rd   = nrd;
                    m_kacc = P_STICKY ? (m_kacc | ke) : ke;
                    m_dacc = P_STICKY ? (m_dacc | de) : de;
                    chk("sb_symbol", o_symbol, s);
                    chk("sb_kerr", o_k_error, m_kacc);
                    chk("sb_derr", o_disp_error, m_dacc);
                    chk("sb_rd", o_rd, m_rd);
                    o.sym = o_symbol; o.rd = o_rd; o.kerr = o_k_error;
                    o.derr = o_disp_error; o.cyc = cyc;
                    obs_q.push_back(o);
                end
            end
            if (i_valid && o_ready) exp_q.push_back({i_k, i_data});
        end
    end

    // ---------------- stimulus helpers ----------------
    int last_acc = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic k);
        int t;
        bit took;
        t = 0;
        took = 1'b0;
        i_valid = 1'b1;
        i_data  = b;
        i_k     = k;
        while (!took) begin
            @(negedge clk);
            took = o_ready;
            step();
            t++;
            if (!took && t > 200) begin
                chk("send_timeout", 1, 0);
                took = 1'b1;
            end
        end
        last_acc = cyc;
    endtask

    task automatic drain();
        int t;
        t = 0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        while ((exp_q.size() != 0 || o_valid) && t < 200) begin
            step();
            t++;
        end
        if (t >= 200) chk("drain_timeout", 1, 0);
    endtask

    localparam logic [9:0] K285_M = 10'b0011111010;
    localparam logic [9:0] K285_P = 10'b1100000101;
    localparam logic [9:0] D215   = 10'b1010101010;
    localparam logic [9:0] D000_M = 10'b1001110100;

    initial begin
        int acc0, t;
        bit done;
        rst = 1'b1; i_valid = 1'b0; i_data = 8'h00; i_k = 1'b0; i_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_oready", o_ready, 1'b0);
        chk("rst_rden", rom_rd_en, 1'b0);
        chk("rst_ovalid", o_valid, 1'b0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_oready", o_ready, 1'b1);
        chk("post_rst_state", {o_valid, o_rd, o_k_error, o_disp_error, o_symbol},
            {1'b0, P_RD_INIT, 1'b0, 1'b0, 10'h000});
        step();

        // K28.5 twice: RD alternation and 2-cycle latency
        obs_q.delete();
        send(8'hBC, 1'b1);
        acc0 = last_acc;
        send(8'hBC, 1'b1);
        i_valid = 1'b0;
        t = 0;
        while (!o_valid && t < 10) begin step(); t++; end
        chk("latency", cyc - acc0, 2);
        drain();
        chk("k285_count", obs_q.size(), 2);
        chk("k285_0", {obs_q[0].sym, obs_q[0].rd, obs_q[0].kerr, obs_q[0].derr}, {K285_M, 3'b100});
        chk("k285_1", {obs_q[1].sym, obs_q[1].rd, obs_q[1].kerr, obs_q[1].derr}, {K285_P, 3'b000});

        // D21.5 x4 at full rate
        obs_q.delete();
        send(8'hB5, 1'b0);
        acc0 = last_acc;
        repeat (3) send(8'hB5, 1'b0);
        chk("in_rate", last_acc - acc0, 3);
        drain();
        chk("d215_count", obs_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("d215", {obs_q[i].sym, obs_q[i].rd}, {D215, 1'b0});
        chk("out_rate", obs_q[3].cyc - obs_q[0].cyc, 3);

        // D0.0 at RD- then K28.5
        obs_q.delete();
        send(8'h00, 1'b0);
        send(8'hBC, 1'b1);
        drain();
        chk("d000", {obs_q[0].sym, obs_q[0].rd}, {D000_M, 1'b0});
        chk("k285_after_d0", {obs_q[1].sym, obs_q[1].rd}, {K285_M, 1'b1});

        // Stall: downstream low for 3 cycles once the first symbol shows
        obs_q.delete();
        fork
            begin
                send(8'hB5, 1'b0);
                send(8'hBC, 1'b1);
                send(8'h00, 1'b0);
                i_valid = 1'b0;
            end
            begin
                int w;
                w = 0;
                while (!o_valid && w < 20) begin step(); w++; end
                i_ready = 1'b0;
                @(negedge clk);
                chk("stall_oready", o_ready, 1'b0);
                repeat (3) step();
                i_ready = 1'b1;
            end
        join
        drain();
        chk("stall_count", obs_q.size(), 3);
        chk("stall_0", {obs_q[0].sym, obs_q[0].rd}, {D215, 1'b1});
        chk("stall_1", {obs_q[1].sym, obs_q[1].rd}, {K285_P, 1'b0});
        chk("stall_2", {obs_q[2].sym, obs_q[2].rd}, {D000_M, 1'b0});

        // Unknown control character
        obs_q.delete();
        send(8'h00, 1'b1);
        send(8'hB5, 1'b0);
        drain();
        chk("kerr_flag", {obs_q[0].kerr, obs_q[0].rd}, {1'b1, 1'b0});
        chk("kerr_next", {obs_q[1].kerr, obs_q[1].rd}, {P_STICKY, 1'b0});

        // ROM returns an all-ones symbol: disparity handling
        obs_q.delete();
        corrupt = 1'b1;
        send(8'hFF, 1'b0);
        send(8'hB5, 1'b0);
        drain();
        corrupt = 1'b0;
        chk("bad_sym", obs_q[0].sym, 10'h3FF);
`ifdef ENC_DISP_CHECK_EN
        chk("bad_flags", {obs_q[0].derr, obs_q[0].rd}, {1'b1, 1'b0});
        chk("bad_next", {obs_q[1].derr, obs_q[1].rd}, {P_STICKY, 1'b0});
`else
        chk("bad_flags", {obs_q[0].derr, obs_q[0].rd}, {1'b0, 1'b1});
        chk("bad_next", {obs_q[1].derr, obs_q[1].rd}, {1'b0, 1'b1});
`endif

        // Reset with two bytes in flight
        i_ready = 1'b0;
        send(8'hB5, 1'b0);
        send(8'h00, 1'b0);
        i_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_state", {o_valid, o_rd, o_symbol}, {1'b0, P_RD_INIT, 10'h000});
        step();
        i_ready = 1'b1;
        obs_q.delete();
        send(8'hBC, 1'b1);
        drain();
        chk("midrst_count", obs_q.size(), 1);
        chk("midrst_k285", obs_q[0].sym, P_RD_INIT ? K285_P : K285_M);

        // Random traffic with random backpressure
        done = 1'b0;
        fork
            begin
                logic [7:0] b;
                logic k;
                int r;
                for (int n = 0; n < 400; n++) begin
                    if ($urandom_range(0, 3) == 0) begin i_valid = 1'b0; step(); end
                    k = ($urandom_range(0, 7) == 0);
                    b = 8'($urandom);
                    if (k) begin
                        r = $urandom_range(0, 9);
                        if (r < 8) b = {3'(r), 5'd28};
                        else if (r == 8) begin
                            case ($urandom_range(0, 3))
                                0: b = {3'd7, 5'd23};
                                1: b = {3'd7, 5'd27};
                                2: b = {3'd7, 5'd29};
                                default: b = {3'd7, 5'd30};
                            endcase
                        end
                    end
                    send(b, k);
                end
                i_valid = 1'b0;
                done = 1'b1;
            end
            begin
                int g;
                g = 0;
                while (!done && g < 20000) begin
                    i_ready = ($urandom_range(0, 3) != 0);
                    step();
                    g++;
                end
            end
        join
        drain();
        chk("final_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
